// File: rtl/mac_tile_pkg.sv
// Shared encodings for the dual-dataflow MAC tile.
// Instruction bit positions and dataflow mode values.
package mac_tile_pkg;

  localparam int INST_LOAD  = 0;
  localparam int INST_EXEC  = 1;
  localparam int INST_DRAIN = 2;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  typedef logic [2:0] inst_t;

endpackage

// File: rtl/mac_tile_dual_mac.sv
// Combinational a*b+c: a unsigned, b signed, wrap at psum_bw.
// Operands are widened to psum_bw first so the product wraps like the sum.
module mac #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic [bw-1:0]      a_i,
  input  logic [bw-1:0]      b_i,
  input  logic [psum_bw-1:0] c_i,
  output logic [psum_bw-1:0] y_o
);

  logic [psum_bw-1:0] ax;
  logic [psum_bw-1:0] bx;

  assign ax  = {{(psum_bw-bw){1'b0}}, a_i};
  assign bx  = {{(psum_bw-bw){b_i[bw-1]}}, b_i};
  assign y_o = ax * bx + c_i;

endmodule

// File: rtl/mac_tile_dual.sv
// Dual WS/OS systolic processing element.
// Optional zero-skip gating: define MAC_TILE_ZERO_SKIP_EN.
module mac_tile_dual
  import mac_tile_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [bw-1:0]      in_w,
  output logic [bw-1:0]      out_e,
  input  logic [2:0]         inst_w,
  output logic [2:0]         inst_e,
  input  logic [psum_bw-1:0] in_n,
  output logic [psum_bw-1:0] out_s,
  output logic               valid_s,
  input  logic               zero
);

  logic [bw-1:0]      a_q, a_d;
  logic [bw-1:0]      b_q, b_d;
  logic [bw-1:0]      w_q, w_d;
  logic [psum_bw-1:0] c_q, c_d;
  logic [psum_bw-1:0] acc_q, acc_d;
  logic               load_ready_q, load_ready_d;
  inst_t              inst_q, inst_d;
  logic               mode_q, mode_d;

  logic os, ld, ex, dr, skip;
  logic [bw-1:0]      mac_a, mac_b;
  logic [psum_bw-1:0] mac_c, mac_y;

`ifdef MAC_TILE_ZERO_SKIP_EN
  assign skip = zero;
`else
  logic unused_zero;
  assign unused_zero = zero;
  assign skip        = 1'b0;
`endif

  assign os = (mode_q == MODE_OS);
  assign ld = inst_w[INST_LOAD];
  assign ex = inst_w[INST_EXEC];
  assign dr = inst_w[INST_DRAIN];

  // WS computes the outgoing psum; OS computes the next accumulator.
  assign mac_a = os ? in_w : a_q;
  assign mac_b = os ? in_n[bw-1:0] : b_q;
  assign mac_c = os ? acc_q : c_q;

  mac #(
    .bw      (bw),
    .psum_bw (psum_bw)
  ) u_mac (
    .a_i (mac_a),
    .b_i (mac_b),
    .c_i (mac_c),
    .y_o (mac_y)
  );

  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    w_d          = w_q;
    c_d          = c_q;
    acc_d        = acc_q;
    load_ready_d = load_ready_q;
    mode_d       = mode_q;
    inst_d       = {inst_w[INST_DRAIN], inst_w[INST_EXEC],
                    load_ready_q ? inst_q[INST_LOAD] : ld};
    if (mode != mode_q) begin
      mode_d       = mode;
      acc_d        = '0;
      c_d          = '0;
      a_d          = '0;
      load_ready_d = 1'b1;
    end else if (!os) begin
      c_d = in_n;
      if (ld && load_ready_q) begin
        b_d          = in_w;
        load_ready_d = 1'b0;
      end
      if (!ld && !ex)
        load_ready_d = 1'b1;
      if (ld || (ex && !skip))
        a_d = in_w;
    end else if (dr) begin
      acc_d = in_n;
    end else if (ex && !skip) begin
      acc_d = mac_y;
      a_d   = in_w;
      w_d   = in_n[bw-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q          <= '0;
      b_q          <= '0;
      w_q          <= '0;
      c_q          <= '0;
      acc_q        <= '0;
      load_ready_q <= 1'b1;
      inst_q       <= '0;
      mode_q       <= MODE_WS;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      w_q          <= w_d;
      c_q          <= c_d;
      acc_q        <= acc_d;
      load_ready_q <= load_ready_d;
      inst_q       <= inst_d;
      mode_q       <= mode_d;
    end
  end

  assign out_e   = skip ? '0 : a_q;
  assign inst_e  = inst_q;
  assign valid_s = os & dr;

  always_comb begin
    if (os)
      out_s = dr ? acc_q : {{(psum_bw-bw){w_q[bw-1]}}, w_q};
    else
      out_s = skip ? c_q : mac_y;
  end

endmodule

// File: tb/tb_mac_tile_dual.sv
// Self-checking bench for mac_tile_dual against an arithmetic model.
// Build with or without MAC_TILE_ZERO_SKIP_EN.
module tb_mac_tile_dual;

  logic        clk = 1'b0;
  logic        reset, mode, zero, valid_s;
  logic [3:0]  in_w, out_e;
  logic [2:0]  inst_w, inst_e;
  logic [15:0] in_n, out_s;
  int          tests = 0;
  int          fails = 0;

  mac_tile_dual #(.bw(4), .psum_bw(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .in_w    (in_w),
    .out_e   (out_e),
    .inst_w  (inst_w),
    .inst_e  (inst_e),
    .in_n    (in_n),
    .out_s   (out_s),
    .valid_s (valid_s),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  function automatic int sw(input logic [3:0] w);
    return w[3] ? int'(w) - 16 : int'(w);
  endfunction

  function automatic logic [15:0] m16(input int v);
    return v[15:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    inst_w = 3'b000; in_w = '0; in_n = '0; zero = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; mode = 1'b0; idle();
    tick(); tick();
    reset = 1'b1;
    #1;
    tests++; if (out_e !== 4'd0) begin fails++; $display("FAIL rst_out_e got %0d want 0", out_e); end
    tests++; if (inst_e !== 3'd0) begin fails++; $display("FAIL rst_inst_e got %0d want 0", inst_e); end
    tests++; if (out_s !== 16'd0) begin fails++; $display("FAIL rst_out_s got %0d want 0", out_s); end
    tests++; if (valid_s !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b want 0", valid_s); end
    tests++; if (dut.load_ready_q !== 1'b1) begin fails++; $display("FAIL rst_load_ready got %0b want 1", dut.load_ready_q); end
    tick();
  endtask

  task automatic test_ws_load_exec;
    inst_w = 3'b001; in_w = 4'b1101;
    tick();
    tests++; if (dut.b_q !== 4'b1101) begin fails++; $display("FAIL ws_b_q got %0d want 13", dut.b_q); end
    tests++; if (inst_e[0] !== 1'b0) begin fails++; $display("FAIL ws_inst_e0_first got %0b want 0", inst_e[0]); end
    tick();
    tests++; if (inst_e[0] !== 1'b1) begin fails++; $display("FAIL ws_inst_e0_second got %0b want 1", inst_e[0]); end
    tick();
    inst_w = 3'b010; in_w = 4'd5; in_n = 16'd100;
    tick();
    tests++; if (out_s !== m16(5 * -3 + 100)) begin fails++; $display("FAIL ws_exec_out_s got %0d want 85", out_s); end
    tests++; if (out_e !== 4'd5) begin fails++; $display("FAIL ws_exec_out_e got %0d want 5", out_e); end
    tests++; if (inst_e !== 3'b010) begin fails++; $display("FAIL ws_exec_inst_e got %b want 010", inst_e); end
  endtask

  task automatic test_ws_rearm;
    idle(); tick();
    inst_w = 3'b001; in_w = 4'd2; tick();
    inst_w = 3'b010; in_w = 4'd7; in_n = 16'd0; tick();
    tests++; if (out_s !== 16'd14) begin fails++; $display("FAIL ws_rearm_out_s got %0d want 14", out_s); end
    tests++; if (dut.b_q !== 4'd2) begin fails++; $display("FAIL ws_rearm_b_q got %0d want 2", dut.b_q); end
  endtask

  task automatic test_zero_skip;
    logic [15:0] exp_s;
    logic [3:0]  exp_e, exp_a;
    // current weight 2, a_q 7 from the re-arm scenario
    inst_w = 3'b010; in_w = 4'd9; in_n = 16'd50; zero = 1'b1;
    tick();
`ifdef MAC_TILE_ZERO_SKIP_EN
    exp_s = 16'd50; exp_e = 4'd0; exp_a = 4'd7;
`else
    exp_s = m16(9 * 2 + 50); exp_e = 4'd9; exp_a = 4'd9;
`endif
    tests++; if (out_s !== exp_s) begin fails++; $display("FAIL zskip_out_s got %0d want %0d", out_s, exp_s); end
    tests++; if (out_e !== exp_e) begin fails++; $display("FAIL zskip_out_e got %0d want %0d", out_e, exp_e); end
    tests++; if (dut.a_q !== exp_a) begin fails++; $display("FAIL zskip_a_q got %0d want %0d", dut.a_q, exp_a); end
    zero = 1'b0;
  endtask

  task automatic test_random_ws;
    logic [3:0]  w, a;
    logic [15:0] c;
    for (int k = 0; k < 12; k++) begin
      idle(); tick();
      w = 4'($urandom);
      inst_w = 3'b001; in_w = w; tick();
      for (int j = 0; j < 5; j++) begin
        a = 4'($urandom); c = 16'($urandom);
        inst_w = 3'b010; in_w = a; in_n = c;
        tick();
        tests++;
        if (out_s !== m16(int'(a) * sw(w) + int'(c)) || out_e !== a) begin
          fails++;
          $display("FAIL ws_rand out_s=%0h out_e=%0d want %0h/%0d (w=%0d)",
                   out_s, out_e, m16(int'(a) * sw(w) + int'(c)), a, sw(w));
        end
      end
    end
  endtask

  task automatic test_mode_switch;
    idle(); mode = 1'b1; tick();
    tests++; if (dut.acc_q !== 16'd0 || out_s !== 16'd0) begin fails++; $display("FAIL mode_sw acc=%0d out_s=%0d want 0/0", dut.acc_q, out_s); end
  endtask

  task automatic test_os_accum;
    logic [3:0] as [3];
    logic [3:0] ws [3];
    int acc;
    as = '{4'd3, 4'd4, 4'd15};
    ws = '{4'd2, 4'hF, 4'd7};
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      inst_w = 3'b010; in_w = as[i]; in_n = {12'hABC, ws[i]};
      tick();
      acc += int'(as[i]) * sw(ws[i]);
      tests++; if (out_s !== m16(sw(ws[i]))) begin fails++; $display("FAIL os_fwd_w[%0d] got %0h want %0h", i, out_s, m16(sw(ws[i]))); end
    end
    tests++; if (dut.acc_q !== 16'd107 || m16(acc) !== 16'd107) begin fails++; $display("FAIL os_acc got %0d want 107", dut.acc_q); end
  endtask

  task automatic test_os_drain_wrap;
    inst_w = 3'b100; in_n = 16'd0;
    #1;
    tests++; if (out_s !== 16'd107 || valid_s !== 1'b1) begin fails++; $display("FAIL os_drain107 out_s=%0d v=%0b want 107/1", out_s, valid_s); end
    tick();
    inst_w = 3'b010; in_w = 4'd1; in_n = 16'h000F; tick();
    tests++; if (dut.acc_q !== 16'hFFFF) begin fails++; $display("FAIL os_preload got %0h want ffff", dut.acc_q); end
    inst_w = 3'b110; in_w = 4'd1; in_n = 16'h0001;
    #1;
    tests++; if (out_s !== 16'hFFFF || valid_s !== 1'b1) begin fails++; $display("FAIL os_drain_over_exec out_s=%0h v=%0b want ffff/1", out_s, valid_s); end
    tick();
    tests++; if (dut.acc_q !== 16'h0001) begin fails++; $display("FAIL os_drain_no_acc got %0h want 1", dut.acc_q); end
    inst_w = 3'b100; in_n = 16'hFFFF; tick();
    inst_w = 3'b010; in_w = 4'd1; in_n = 16'h0001; tick();
    tests++; if (dut.acc_q !== 16'h0000) begin fails++; $display("FAIL os_wrap got %0h want 0", dut.acc_q); end
    inst_w = 3'b100; in_n = 16'h1234;
    #1;
    tests++; if (out_s !== 16'h0000 || valid_s !== 1'b1) begin fails++; $display("FAIL os_drain0 out_s=%0h v=%0b want 0/1", out_s, valid_s); end
    tick();
    in_n = 16'h0000;
    #1;
    tests++; if (out_s !== 16'h1234 || valid_s !== 1'b1) begin fails++; $display("FAIL os_drain1234 out_s=%0h v=%0b want 1234/1", out_s, valid_s); end
    tick();
    idle();
    #1;
    tests++; if (valid_s !== 1'b0) begin fails++; $display("FAIL os_valid_drop got %0b want 0", valid_s); end
  endtask

  task automatic test_random_os;
    int          acc;
    logic [3:0]  a, w;
    logic [15:0] d;
    acc = 0;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        d = 16'($urandom);
        inst_w = 3'b100; in_n = d;
        #1;
        tests++;
        if (out_s !== m16(acc) || valid_s !== 1'b1) begin
          fails++;
          $display("FAIL os_rand_drain out_s=%0h v=%0b want %0h/1", out_s, valid_s, m16(acc));
        end
        tick();
        acc = int'(d);
      end else begin
        a = 4'($urandom); w = 4'($urandom);
        inst_w = 3'b010; in_w = a; in_n = {12'($urandom), w};
        tick();
        acc = int'(m16(acc + int'(a) * sw(w)));
        tests++;
        if (out_s !== m16(sw(w)) || out_e !== a) begin
          fails++;
          $display("FAIL os_rand_exec out_s=%0h out_e=%0d want %0h/%0d", out_s, out_e, m16(sw(w)), a);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    inst_w = 3'b010; in_w = 4'd9; in_n = 16'h0005; tick();
    mode = 1'b0;
    #2 reset = 1'b0;
    #1;
    tests++;
    if (out_s !== 16'd0 || out_e !== 4'd0 || inst_e !== 3'd0 || valid_s !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset out_s=%0h out_e=%0d inst_e=%b v=%0b want all 0", out_s, out_e, inst_e, valid_s);
    end
    tests++; if (dut.load_ready_q !== 1'b1 || dut.acc_q !== 16'd0) begin fails++; $display("FAIL mid_reset_state lr=%0b acc=%0h want 1/0", dut.load_ready_q, dut.acc_q); end
    idle();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_ws_load_exec();
    test_ws_rearm();
    test_zero_skip();
    test_random_ws();
    test_mode_switch();
    test_os_accum();
    test_os_drain_wrap();
    test_random_os();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_tile_dual.md
# mac_tile_dual

Parametrised dual-dataflow processing element for the systolic MAC array, successor to the single-mode weight-stationary tile. Supports weight-stationary (WS) and output-stationary (OS) operation selected per tile. Adds re-armable kernel loading without reset, an OS accumulator drained as a south-going shift chain, and optional zero-skip gating. Sits at every array position: activations flow west→east, psums or weights flow north→south, instructions flow west→east.

## Interface
- `bw`, 4: activation/weight width.
- `psum_bw`, 16: psum/accumulator width.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `mode` input 1: 0 = WS, 1 = OS; registered internally as `mode_q`.
- `in_w` input bw: activation, or weight during WS load.
- `out_e` output bw: forwarded activation.
- `inst_w` input 3: [0] kernel load, [1] execute, [2] drain (OS only).
- `inst_e` output 3: forwarded instruction.
- `in_n` input psum_bw: WS psum in; OS weight in `[bw-1:0]` during execute, upstream accumulator during drain.
- `out_s` output psum_bw: WS psum out; OS forwarded weight or drained accumulator.
- `valid_s` output 1: high while `out_s` carries a drained OS accumulator.
- `zero` input 1: operand-is-zero flag.

## Operation
- Arithmetic: activation unsigned `bw`, weight signed `bw`. Product is sign-extended to `psum_bw`. All sums wrap modulo 2^psum_bw; no saturation.
- State: `a_q`, `b_q` (WS weight), `w_q` (OS forwarded weight), `c_q`, `acc_q`, `load_ready_q`, `inst_q[2:0]`, `mode_q`.
- WS load: `inst_w[0]=1` with `load_ready_q=1` gives `b_q<=in_w` and `load_ready_q<=0`. Further load cycles forward the weight east through `a_q`.
- WS load re-arm: `load_ready_q<=1` on any cycle with `inst_w[1:0]==0`. This allows reloading per kernel index without reset.
- WS `a_q`: `a_q<=in_w` when `inst_w[0]|inst_w[1]`.
- WS psum: `c_q<=in_n` every cycle. `out_s = a_q*b_q + c_q`.
- OS execute (`inst_w[1]=1`, `inst_w[2]=0`):
  - `acc_q <= acc_q + in_w*in_n[bw-1:0]`.
  - `a_q<=in_w`, `w_q<=in_n[bw-1:0]`.
  - `out_s` = sign-extended `w_q`.
- OS drain (`inst_w[2]=1`): `out_s=acc_q`, `valid_s=1`, and `acc_q<=in_n` at the edge. Drain overrides a simultaneous execute, so no accumulate happens that cycle.
- OS ignores `inst_w[0]`.
- `inst_e` forwarding:
  - `inst_e[1]` and `inst_e[2]` are `inst_w` delayed one cycle.
  - `inst_e[0]` updates from `inst_w[0]` only while `load_ready_q=0`, so downstream tiles see load one cycle after this tile has captured its weight.
- Mode change: when `mode` differs from `mode_q`, the next edge clears `acc_q`, `c_q` and `a_q`, sets `load_ready_q=1`, and updates `mode_q`. `mode` may change only while `inst_w==0`.

## Timing
- Reset values: `out_e=0`, `inst_e=0`, `out_s=0`, `valid_s=0`; all registers 0 except `load_ready_q=1`.
- Reset asserted mid-operation clears state immediately (asynchronously), discarding any partial accumulation.
- Latency: inputs sampled at edge k are visible on `out_e`, `inst_e` and `out_s` after edge k (one register stage). `out_s` and `valid_s` are combinational from registers plus `inst_w[2]` and `mode_q`.
- OS drain of an N-row column: the bottom tile's `out_s` presents rows N-1…0 over N consecutive drain cycles.

## Configuration
- `MAC_TILE_ZERO_SKIP_EN` defined:
  - With `zero=1`, `a_q`, `w_q` and `acc_q` hold and `out_e=0`.
  - WS: `c_q<=in_n` still updates and `out_s=c_q`; the product is bypassed.
  - Drain and load are unaffected by `zero`.
- Undefined: the `zero` port exists but is ignored; datapath as in Operation.

## Structure
- Shared package `mac_tile_pkg` holds:
  - instruction bit indices `INST_LOAD=0`, `INST_EXEC=1`, `INST_DRAIN=2`;
  - mode encodings `MODE_WS=0`, `MODE_OS=1`.
- One sub-module, `mac`: combinational `a*b+c` with the width rules above. The OS accumulate reuses it with `c=acc_q`.

## Test plan
- WS load then execute:
  - Stimulus: load `in_w=4'b1101` (−3) for 3 cycles, then execute `in_w=5`, `in_n=100`.
  - Response: `b_q=−3`; `inst_e[0]` rises one cycle after the first load; `out_s=85`.
- WS re-arm: one idle cycle then load `in_w=2`, execute `in_w=7`, `in_n=0` → `out_s=14`, with no reset.
- OS accumulate: 3 execute cycles with (`in_w`, weight) = (3,2), (4,−1), (15,7) → `acc_q=107`; `out_s` follows forwarded weights 2, −1, 7.
- OS drain and wrap:
  - Preload `acc_q=16'hFFFF` via execute steps, then accumulate +1 → `acc_q=0`.
  - Drain with `in_n=0x1234` → `out_s=0` with `valid_s=1`, then `out_s=0x1234`.
- Mid-operation reset: drop `reset` during OS execute → all outputs 0 asynchronously, `load_ready_q=1`.
- Zero-skip with macro: WS execute with `zero=1`, `in_n=50` → `out_s=50`, `out_e=0`, `a_q` held. Without macro the same stimulus gives the normal MAC result.
